// File: rtl/fibo_sequencer_if.sv
// rtl/fibo_sequencer_if.sv - request/term/result bundle between the Fibonacci sequencer and its user
//
// Ports: Start, N (request side, driven by master); Busy, Done, Term,
// Term_Valid, Result, Overflow (status/data, driven by slave).
interface fibo_sequencer_if #(
    parameter int size  = 4,
    parameter int cnt_w = 4
);
    logic             Start;
    logic [cnt_w-1:0] N;
    logic             Busy;
    logic             Done;
    logic [size-1:0]  Term;
    logic             Term_Valid;
    logic [size-1:0]  Result;
    logic             Overflow;

    modport master (
        output Start, N,
        input  Busy, Done, Term, Term_Valid, Result, Overflow
    );

    modport slave (
        input  Start, N,
        output Busy, Done, Term, Term_Valid, Result, Overflow
    );
endinterface

// File: rtl/fibo_sequencer.sv
// rtl/fibo_sequencer.sv - iterative Fibonacci term generator with streamed terms and sticky overflow
//
// Ports: Clk (rising edge), Reset (async, active-high), bus (slave modport):
//   Start/N request, Busy/Term_Valid high while running, Term = current term,
//   Done one-cycle pulse, Result/Overflow = F(N) mod 2^size and its overflow flag.
module fibo_sequencer #(
    parameter int size  = 4,
    parameter int cnt_w = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    fibo_sequencer_if.slave      bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [size-1:0]  a;
    logic [size-1:0]  b;
    logic             ov_a;
    logic             ov_b;
    logic [cnt_w-1:0] cnt;
    logic [cnt_w-1:0] nl;
    logic [size-1:0]  result_q;
    logic             overflow_q;

    // One extra bit keeps the carry of the add; only the low bits become the next B.
    logic [size:0] sum;
    assign sum = {1'b0, a} + {1'b0, b};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.Start) next_state = RUN;
            RUN:     if (cnt == nl) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.Busy       = (state == RUN);
        bus.Term_Valid = (state == RUN);
        bus.Done       = (state == DONE);
        bus.Term       = a;
        bus.Result     = result_q;
        bus.Overflow   = overflow_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a          <= '0;
            b          <= '0;
            ov_a       <= 1'b0;
            ov_b       <= 1'b0;
            cnt        <= '0;
            nl         <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        nl   <= bus.N;
                        a    <= '0;
                        b    <= size'(1);
                        ov_a <= 1'b0;
                        ov_b <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    if (cnt == nl) begin
                        result_q   <= a;
                        overflow_q <= ov_a;
                    end else begin
                        // Overflow tags travel with their register so that only an
                        // output term's own history decides the final flag.
                        a    <= b;
                        b    <= sum[size-1:0];
                        ov_a <= ov_b;
                        ov_b <= ov_a | ov_b | sum[size];
                        cnt  <= cnt + cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
